// File: rtl/toast_mem_stage.sv
// toast_mem_stage: MEM pipeline stage running loads/stores over a req/gnt/rvalid bus,
// with byte lanes, load extension, stall generation and exception flagging.
module toast_mem_stage #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        EX_mem_rd_en_i,
  input  logic        EX_mem_wr_en_i,
  input  logic [3:0]  EX_mem_op_i,
  input  logic [31:0] EX_alu_result_i,
  input  logic [31:0] EX_rs2_data_i,
  input  logic        EX_memtoreg_i,
  input  logic        EX_rd_wr_en_i,
  input  logic [4:0]  EX_rd_addr_i,
  input  logic        EX_exception_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic        dmem_err_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        MEM_stall_o,
  output logic        MEM_rd_wr_en_o,
  output logic [4:0]  MEM_rd_addr_o,
  output logic [31:0] MEM_alu_result_o,
  output logic [31:0] MEM_rd_wr_data_o,
  output logic        MEM_exception_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] cnt, rdata_q, w, ld, wdata_nx;
  logic [3:0] be_nx;
  logic [2:0] op_q;
  logic [1:0] a, off_q;
  logic err_q, mem_op, misal, access, fault, exc_nx, to, unused_op;
  assign a = EX_alu_result_i[1:0];
  assign mem_op = EX_mem_rd_en_i | EX_mem_wr_en_i;
  assign misal = mem_op & (EX_mem_op_i[1] ? |a : EX_mem_op_i[0] & a[0]);
  assign access = mem_op & ~EX_exception_i & ~misal;
  assign fault = EX_exception_i | misal;
  assign exc_nx = state == DONE ? err_q : fault;
  assign to = (WAIT_TIMEOUT != 0) && (cnt == WAIT_TIMEOUT - 1);
  assign MEM_stall_o = (state == IDLE && access) || state == REQ || state == WAIT;
  assign dmem_req_o = state == REQ;
  assign unused_op = EX_mem_op_i[3];
  // A timeout in REQ wins over a same-cycle gnt so the request is abandoned cleanly
  always_comb begin
    state_nx = state == IDLE ? (access ? REQ : IDLE) :
               state == REQ  ? (to ? DONE : dmem_gnt_i ? WAIT : REQ) :
               state == WAIT ? (dmem_rvalid_i || to ? DONE : WAIT) : IDLE;
    be_nx = EX_mem_op_i[1] ? 4'b1111 : EX_mem_op_i[0] ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
    wdata_nx = EX_mem_op_i[1] ? EX_rs2_data_i : EX_mem_op_i[0] ? {2{EX_rs2_data_i[15:0]}} : {4{EX_rs2_data_i[7:0]}};
    w = rdata_q >> {off_q, 3'b000};
    ld = op_q[1] ? rdata_q :
         op_q[0] ? {{16{~op_q[2] & w[15]}}, w[15:0]} : {{24{~op_q[2] & w[7]}}, w[7:0]};
  end
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state <= IDLE;
      cnt <= '0;
      dmem_we_o <= 1'b0;
      dmem_addr_o <= '0;
      dmem_be_o <= '0;
      dmem_wdata_o <= '0;
      op_q <= '0;
      off_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= (state == REQ || state == WAIT) ? cnt + 1 : '0;
      if (state == IDLE && access) begin
        dmem_we_o <= EX_mem_wr_en_i;
        dmem_addr_o <= {EX_alu_result_i[31:2], 2'b00};
        dmem_be_o <= be_nx;
        dmem_wdata_o <= wdata_nx;
        op_q <= EX_mem_op_i[2:0];
        off_q <= a;
      end
      if (state == IDLE) err_q <= 1'b0;
      else if (state == WAIT && dmem_rvalid_i) begin
        rdata_q <= dmem_rdata_i;
        err_q <= dmem_err_i;
      end else if (to && state != DONE) err_q <= 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      MEM_rd_wr_en_o <= 1'b0;
      MEM_rd_addr_o <= '0;
      MEM_alu_result_o <= '0;
      MEM_rd_wr_data_o <= '0;
      MEM_exception_o <= 1'b0;
    end else if (MEM_stall_o) begin
      MEM_rd_wr_en_o <= 1'b0;
      MEM_exception_o <= 1'b0;
    end else begin
      MEM_rd_addr_o <= EX_rd_addr_i;
      MEM_alu_result_o <= EX_alu_result_i;
      MEM_exception_o <= exc_nx;
      MEM_rd_wr_en_o <= EX_rd_wr_en_i & ~exc_nx;
      MEM_rd_wr_data_o <= (state == DONE && EX_memtoreg_i) ? ld : EX_alu_result_i;
    end
  end
endmodule

// File: tb/tb_toast_mem_stage.sv
// tb_toast_mem_stage: directed stimulus against a transaction-level model of the MEM stage.
module tb_toast_mem_stage;
  localparam int T = 8;
  logic clk = 1'b0, resetn = 1'b0;
  logic ex_rd = 0, ex_wr = 0, ex_m2r = 0, ex_rwe = 0, ex_exc = 0;
  logic [3:0] ex_op = 0;
  logic [31:0] ex_alu = 0, ex_rs2 = 0;
  logic [4:0] ex_rda = 0;
  logic gnt = 0, rvalid = 0, err = 0;
  logic [31:0] rdata = 0;
  logic req, we, stall, rwe, exc;
  logic [31:0] addr, wdata, alu, data;
  logic [3:0] be;
  logic [4:0] rda;
  int checks = 0, errors = 0, stall_cnt = 0, req_cnt = 0;
  logic chk_on = 0, exp_stall = 0, exp_req = 0, exp_we = 0, exp_rwe = 0, exp_exc = 0, exp_full = 1;
  logic [31:0] exp_addr = 0, exp_wdata = 0, exp_alu = 0, exp_data = 0, seen_addr = 0, seen_wdata = 0;
  logic [3:0] exp_be = 0, seen_be = 0;
  logic [4:0] exp_rd = 0;

  toast_mem_stage #(.WAIT_TIMEOUT(T)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .EX_mem_rd_en_i(ex_rd), .EX_mem_wr_en_i(ex_wr), .EX_mem_op_i(ex_op),
    .EX_alu_result_i(ex_alu), .EX_rs2_data_i(ex_rs2), .EX_memtoreg_i(ex_m2r),
    .EX_rd_wr_en_i(ex_rwe), .EX_rd_addr_i(ex_rda), .EX_exception_i(ex_exc),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_be_o(be), .dmem_wdata_o(wdata),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_err_i(err), .dmem_rdata_i(rdata),
    .MEM_stall_o(stall), .MEM_rd_wr_en_o(rwe), .MEM_rd_addr_o(rda),
    .MEM_alu_result_o(alu), .MEM_rd_wr_data_o(data), .MEM_exception_o(exc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int sz(input logic [3:0] op);
    case (op[2:0])
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++) r[i] = (i >= int'(a[1:0])) && (i < int'(a[1:0]) + sz(op));
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz(op)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r = '0;
    int s = sz(op), off = int'(a[1:0]);
    for (int i = 0; i < s; i++) r[8*i +: 8] = d[8*(off + i) +: 8];
    if (!op[2] && s < 4 && r[8*s-1])
      for (int i = s; i < 4; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  always @(negedge clk) if (chk_on) begin
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("req", 32'(req), 32'(exp_req));
    if (exp_req) begin
      chk("addr", addr, exp_addr);
      chk("we", 32'(we), 32'(exp_we));
      if (exp_we) begin
        chk("be", 32'(be), 32'(exp_be));
        chk("wdata", wdata, exp_wdata);
      end
      seen_addr = addr; seen_be = be; seen_wdata = wdata;
    end
    if (stall) stall_cnt++;
    if (req) req_cnt++;
    chk("rd_wr_en", 32'(rwe), 32'(exp_rwe));
    chk("exception", 32'(exc), 32'(exp_exc));
    if (exp_full) begin
      chk("rd_addr", 32'(rda), 32'(exp_rd));
      chk("alu_result", alu, exp_alu);
      if (!exp_exc) chk("rd_wr_data", data, exp_data);
    end
  end

  // g: REQ cycle (0-based) carrying gnt, -1 none; r: WAIT cycle carrying rvalid, -1 none
  task automatic run(input logic rd, input logic wr, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] rs2, input logic m2r, input logic rw, input logic [4:0] rdx,
                     input logic ex, input int g, input int r, input logic e, input logic [31:0] rdat);
    logic misal, acc, granted, responded, fault;
    int busy, reqc, last;
    misal = (rd || wr) && (int'(a[1:0]) % sz(op) != 0);
    acc = (rd || wr) && !ex && !misal;
    granted = g >= 0 && g < T - 1;
    responded = granted && r >= 0 && r <= T - g - 2;
    busy = responded ? g + r + 2 : T;
    reqc = granted ? g + 1 : T;
    last = acc ? busy + 1 : 0;
    ex_rd = rd; ex_wr = wr; ex_op = op; ex_alu = a; ex_rs2 = rs2;
    ex_m2r = m2r; ex_rwe = rw; ex_rda = rdx; ex_exc = ex; rdata = rdat;
    stall_cnt = 0; req_cnt = 0;
    exp_addr = {a[31:2], 2'b00}; exp_we = wr; exp_be = m_be(op, a); exp_wdata = m_wdata(op, rs2);
    for (int k = 0; k <= last; k++) begin
      exp_stall = acc && k <= busy;
      exp_req = acc && k >= 1 && k <= reqc;
      gnt = acc && g >= 0 && k == 1 + g && k <= reqc;
      rvalid = responded && k == 2 + g + r;
      err = rvalid && e;
      @(posedge clk); #1;
      gnt = 0; rvalid = 0; err = 0;
      if (k < last) begin
        exp_rwe = 0; exp_exc = 0; exp_full = 0;
      end
    end
    fault = ex || misal || (acc && (!responded || e));
    exp_stall = 0; exp_req = 0;
    exp_exc = fault; exp_rwe = rw && !fault; exp_full = 1;
    exp_rd = rdx; exp_alu = a;
    exp_data = (acc && m2r) ? m_load(op, a, rdat) : a;
    ex_rd = 0; ex_wr = 0; ex_op = 0; ex_alu = 0; ex_rs2 = 0; ex_m2r = 0; ex_rwe = 0; ex_rda = 0; ex_exc = 0;
  endtask

  initial begin
    #2;
    chk("reset_req", 32'(req), 0);
    chk("reset_stall", 32'(stall), 0);
    chk("reset_mem", {rwe, exc, rda, be, we}, 0);
    chk("reset_data", data | alu | addr | wdata, 0);
    #10 resetn = 1;
    @(posedge clk); #1;
    chk_on = 1;
    run(1, 0, 4'd2, 32'h100, 0, 1, 1, 5'd5, 0, 0, 0, 0, 32'hDEADBEEF);
    chk("lw_stall_cycles", 32'(stall_cnt), 3);
    chk("lw_data", data, 32'hDEADBEEF);
    chk("lw_rd_wr_en", 32'(rwe), 1);
    run(1, 0, 4'd0, 32'h103, 0, 1, 1, 5'd6, 0, 0, 0, 0, 32'h80123456);
    chk("lb_data", data, 32'hFFFFFF80);
    run(1, 0, 4'd4, 32'h103, 0, 1, 1, 5'd7, 0, 1, 1, 0, 32'h80123456);
    chk("lbu_data", data, 32'h00000080);
    run(1, 0, 4'd5, 32'h102, 0, 1, 1, 5'd8, 0, 0, 2, 0, 32'hBEEF0000);
    chk("lhu_data", data, 32'h0000BEEF);
    run(1, 0, 4'd1, 32'h102, 0, 1, 1, 5'd9, 0, 0, 0, 0, 32'hBEEF0000);
    run(0, 1, 4'd1, 32'h106, 32'h1234ABCD, 0, 0, 5'd0, 0, 3, 1, 0, 0);
    chk("sh_be", 32'(seen_be), 32'hC);
    chk("sh_wdata", seen_wdata, 32'hABCDABCD);
    chk("sh_addr", seen_addr, 32'h104);
    chk("sh_req_cycles", 32'(req_cnt), 4);
    run(0, 1, 4'd0, 32'h201, 32'h000000EF, 0, 0, 5'd0, 0, 1, 0, 0, 0);
    run(0, 1, 4'd2, 32'h300, 32'hCAFEF00D, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    run(1, 0, 4'd2, 32'h102, 0, 1, 1, 5'd3, 0, 0, 0, 0, 0);
    chk("mis_req_cycles", 32'(req_cnt), 0);
    chk("mis_exception", 32'(exc), 1);
    chk("mis_rd_wr_en", 32'(rwe), 0);
    run(0, 0, 4'd0, 32'h55, 0, 0, 1, 5'd4, 0, 0, 0, 0, 0);
    chk("add_stall_cycles", 32'(stall_cnt), 0);
    chk("add_data", data, 32'h55);
    run(0, 1, 4'd2, 32'h400, 32'h11223344, 0, 0, 5'd0, 0, 0, 0, 1, 0);
    chk("sw_err_exception", 32'(exc), 1);
    run(1, 0, 4'd2, 32'h500, 0, 1, 1, 5'd2, 1, 0, 0, 0, 0);
    run(1, 0, 4'd1, 32'h101, 0, 1, 1, 5'd2, 0, 0, 0, 0, 0);
    run(1, 0, 4'd2, 32'h600, 0, 1, 1, 5'd10, 0, 2, -1, 0, 0);
    chk("to_stall_cycles", 32'(stall_cnt), 9);
    chk("to_exception", 32'(exc), 1);
    run(1, 0, 4'd2, 32'h700, 0, 1, 1, 5'd11, 0, -1, -1, 0, 0);
    chk("to_req_cycles", 32'(req_cnt), 8);
    run(0, 0, 4'd0, 32'h77, 0, 0, 1, 5'd12, 0, 0, 0, 0, 0);
    run(1, 0, 4'd2, 32'h800, 0, 1, 1, 5'd13, 0, 0, 0, 0, 32'h01020304);
    chk_on = 0;
    ex_rd = 1; ex_op = 4'd2; ex_alu = 32'h200; ex_m2r = 1; ex_rwe = 1; ex_rda = 5'd1;
    @(posedge clk); #1 gnt = 1;
    @(posedge clk); #1 gnt = 0;
    chk("rst_wait_stall", 32'(stall), 1);
    ex_rd = 0; ex_op = 0; ex_alu = 0; ex_m2r = 0; ex_rwe = 0; ex_rda = 0;
    #1 resetn = 0;
    #1;
    chk("rst_req_drop", 32'(req), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mem", {rwe, exc, rda}, 0);
    chk("rst_data", data | alu, 0);
    @(posedge clk); #1 resetn = 1;
    @(posedge clk); #1 rvalid = 1; err = 1; rdata = 32'h12345678;
    @(posedge clk); #1 rvalid = 0; err = 0;
    @(posedge clk); #1;
    chk("stale_stall", 32'(stall), 0);
    chk("stale_req", 32'(req), 0);
    chk("stale_mem", {rwe, exc, rda}, 0);
    chk("stale_data", data | alu, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
